router_input_unit: RTL and testbench



---
 rtl/router_input_unit.sv | 180 ++++++++++++++++++
 tb/tb_router_input_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_unit.sv
// Router input unit: buffers flits from one upstream link in a circular FIFO,
// requests the switch allocator with the head flit, and registers each granted
// flit into a single switch-traversal stage toward the crossbar.
//
// Starvation FSM states:
//   state  | meaning
//   S_IDLE | no request pending, or the head was granted this cycle
//   S_WAIT | head is requesting and has gone ungranted; wait counter running
module router_input_unit #(
  parameter int DEPTH             = 4,
  parameter int DATA_WIDTH        = 32,
  parameter int STARVE_LIMIT      = 15,
  parameter int ROUTER_INFO_WIDTH = 2,
  parameter int ROUTER_ADDR_WIDTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [ROUTER_INFO_WIDTH-1:0] i_in_info,
  input  logic [ROUTER_ADDR_WIDTH-1:0] i_in_addr,
  input  logic [DATA_WIDTH-1:0]        i_in_data,
  output logic                         o_sa_request,
  output logic [ROUTER_INFO_WIDTH-1:0] o_sa_info,
  output logic [ROUTER_ADDR_WIDTH-1:0] o_sa_addr,
  input  logic                         i_sa_grant,
  output logic                         o_st_valid,
  output logic [ROUTER_INFO_WIDTH-1:0] o_st_info,
  output logic [ROUTER_ADDR_WIDTH-1:0] o_st_addr,
  output logic [DATA_WIDTH-1:0]        o_st_data,
  output logic                         o_sa_starve,
  output logic [$clog2(DEPTH+1)-1:0]   o_occupancy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WORD_W = ROUTER_INFO_WIDTH + ROUTER_ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  logic [WORD_W-1:0]            r_mem [DEPTH];
  logic [PTR_W-1:0]             r_wr_ptr;
  logic [PTR_W-1:0]             r_rd_ptr;
  logic [CNT_W-1:0]             r_count;
  state_t                       r_state;
  logic [7:0]                   r_wait_cnt;
  logic                         r_starve;
  logic                         r_st_valid;
  logic [ROUTER_INFO_WIDTH-1:0] r_st_info;
  logic [ROUTER_ADDR_WIDTH-1:0] r_st_addr;
  logic [DATA_WIDTH-1:0]        r_st_data;

  logic                         w_ready;
  logic                         w_request;
  logic                         w_push;
  logic                         w_pop;
  logic [WORD_W-1:0]            w_head;
  logic [ROUTER_INFO_WIDTH-1:0] w_head_info;
  logic [ROUTER_ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0]        w_head_data;
  state_t                       w_state_nxt;
  logic [7:0]                   w_wait_cnt_nxt;
  logic                         w_starve_nxt;

  // Handshake decode; ready looks only at the registered count, so a pop in
  // the same cycle never frees a slot for a push.
  always_comb begin
    w_ready     = (r_count != CNT_W'(DEPTH));
    w_request   = (r_count != '0);
    w_push      = i_in_valid && w_ready;
    w_pop       = w_request && i_sa_grant;
    w_head      = r_mem[r_rd_ptr];
    w_head_info = w_head[WORD_W-1 -: ROUTER_INFO_WIDTH];
    w_head_addr = w_head[DATA_WIDTH +: ROUTER_ADDR_WIDTH];
    w_head_data = w_head[DATA_WIDTH-1:0];
  end

  // FIFO storage; contents need no reset because the count gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_in_info, i_in_addr, i_in_data};
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Switch-traversal stage: capture the head on a pop, otherwise hold fields.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st_valid <= 1'b0;
      r_st_info  <= '0;
      r_st_addr  <= '0;
      r_st_data  <= '0;
    end else if (w_pop) begin
      r_st_valid <= 1'b1;
      r_st_info  <= w_head_info;
      r_st_addr  <= w_head_addr;
      r_st_data  <= w_head_data;
    end else begin
      r_st_valid <= 1'b0;
    end
  end

  // Starvation FSM next state. The counter counts ungranted request cycles,
  // including the one that leaves IDLE, and the starve flag is cleared on
  // the granting edge so it drops the cycle right after the pop.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_starve_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_wait_cnt_nxt = 8'd0;
        if (w_request && !w_pop) begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = 8'd1;
        end
      end
      S_WAIT: begin
        if (w_pop || !w_request) begin
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = 8'd0;
        end else begin
          if (r_wait_cnt != 8'hFF) w_wait_cnt_nxt = r_wait_cnt + 8'd1;
          w_starve_nxt = (r_wait_cnt >= 8'(STARVE_LIMIT));
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Starvation FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 8'd0;
      r_starve   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_starve   <= w_starve_nxt;
    end
  end

  // Output drive; the allocator sees zeros rather than stale data when empty.
  always_comb begin
    o_in_ready   = w_ready;
    o_sa_request = w_request;
    o_sa_info    = w_request ? w_head_info : '0;
    o_sa_addr    = w_request ? w_head_addr : '0;
    o_st_valid   = r_st_valid;
    o_st_info    = r_st_info;
    o_st_addr    = r_st_addr;
    o_st_data    = r_st_data;
    o_sa_starve  = r_starve;
    o_occupancy  = r_count;
  end

endmodule

// File: tb/tb_router_input_unit.sv
// Directed testbench for router_input_unit. Inputs are driven and outputs are
// sampled on the falling edge, half a cycle away from the active edge.
module tb_router_input_unit;

  localparam int DEPTH        = 4;
  localparam int DATA_WIDTH   = 32;
  localparam int STARVE_LIMIT = 15;
  localparam int INFO_W       = 2;
  localparam int ADDR_W       = 8;
  localparam logic [INFO_W-1:0] INFO_BROADCAST     = 2'd1;
  localparam logic [INFO_W-1:0] INFO_FIN_BROADCAST = 2'd2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [INFO_W-1:0] in_info = '0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_WIDTH-1:0] in_data = '0;
  logic              sa_request;
  logic [INFO_W-1:0] sa_info;
  logic [ADDR_W-1:0] sa_addr;
  logic              sa_grant = 1'b0;
  logic              st_valid;
  logic [INFO_W-1:0] st_info;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic              sa_starve;
  logic [2:0]        occupancy;

  int n_checks = 0;
  int n_errors = 0;

  router_input_unit #(
    .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .STARVE_LIMIT(STARVE_LIMIT),
    .ROUTER_INFO_WIDTH(INFO_W), .ROUTER_ADDR_WIDTH(ADDR_W)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_info(in_info), .i_in_addr(in_addr), .i_in_data(in_data),
    .o_sa_request(sa_request), .o_sa_info(sa_info), .o_sa_addr(sa_addr),
    .i_sa_grant(sa_grant),
    .o_st_valid(st_valid), .o_st_info(st_info), .o_st_addr(st_addr),
    .o_st_data(st_data),
    .o_sa_starve(sa_starve), .o_occupancy(occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    n_checks++; if (sa_request !== 1'b0) begin n_errors++; $display("FAIL reset_sa_request: got %0b expected 0", sa_request); end
    n_checks++; if (occupancy !== 3'd0) begin n_errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    n_checks++; if (st_valid !== 1'b0) begin n_errors++; $display("FAIL reset_st_valid: got %0b expected 0", st_valid); end
    n_checks++; if (sa_starve !== 1'b0) begin n_errors++; $display("FAIL reset_sa_starve: got %0b expected 0", sa_starve); end
    n_checks++; if (sa_addr !== 8'd0 || sa_info !== 2'd0) begin n_errors++; $display("FAIL reset_sa_fields: got info=%0d addr=%0d expected 0/0", sa_info, sa_addr); end
  endtask

  task automatic test_single_flit();
    in_valid = 1'b1; in_info = INFO_BROADCAST; in_addr = 8'd5; in_data = 32'hA5;
    tick();
    in_valid = 1'b0;
    n_checks++; if (sa_request !== 1'b1) begin n_errors++; $display("FAIL single_request: got %0b expected 1", sa_request); end
    n_checks++; if (sa_addr !== 8'd5) begin n_errors++; $display("FAIL single_sa_addr: got %0d expected 5", sa_addr); end
    n_checks++; if (sa_info !== INFO_BROADCAST) begin n_errors++; $display("FAIL single_sa_info: got %0d expected %0d", sa_info, INFO_BROADCAST); end
    n_checks++; if (occupancy !== 3'd1) begin n_errors++; $display("FAIL single_occupancy: got %0d expected 1", occupancy); end
    n_checks++; if (st_valid !== 1'b0) begin n_errors++; $display("FAIL single_st_idle: got %0b expected 0", st_valid); end
    sa_grant = 1'b1;
    tick();
    sa_grant = 1'b0;
    n_checks++; if (st_valid !== 1'b1) begin n_errors++; $display("FAIL single_st_valid: got %0b expected 1", st_valid); end
    n_checks++; if (st_data !== 32'hA5) begin n_errors++; $display("FAIL single_st_data: got %0h expected a5", st_data); end
    n_checks++; if (st_addr !== 8'd5 || st_info !== INFO_BROADCAST) begin n_errors++; $display("FAIL single_st_fields: got info=%0d addr=%0d expected 1/5", st_info, st_addr); end
    n_checks++; if (occupancy !== 3'd0) begin n_errors++; $display("FAIL single_occ_after: got %0d expected 0", occupancy); end
    n_checks++; if (sa_request !== 1'b0) begin n_errors++; $display("FAIL single_request_after: got %0b expected 0", sa_request); end
    tick();
    n_checks++; if (st_valid !== 1'b0 || st_data !== 32'hA5) begin n_errors++; $display("FAIL single_st_hold: got valid=%0b data=%0h expected 0/a5", st_valid, st_data); end
  endtask

  task automatic test_fill_wrap();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_info = INFO_FIN_BROADCAST; in_addr = 8'(i); in_data = 32'h100 + 32'(i);
      tick();
    end
    n_checks++; if (occupancy !== 3'd4) begin n_errors++; $display("FAIL fill_occupancy: got %0d expected 4", occupancy); end
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL fill_in_ready: got %0b expected 0", in_ready); end
    in_addr = 8'd9; in_data = 32'h999;
    tick();
    n_checks++; if (occupancy !== 3'd4) begin n_errors++; $display("FAIL fill_fifth_rejected: got %0d expected 4", occupancy); end
    // full with a pop: the push still must not happen this cycle
    sa_grant = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      in_valid = 1'b0;
      n_checks++; if (st_valid !== 1'b1 || st_addr !== 8'(i) || st_data !== 32'h100 + 32'(i)) begin
        n_errors++; $display("FAIL fill_drain_%0d: got valid=%0b addr=%0d data=%0h expected 1/%0d/%0h", i, st_valid, st_addr, st_data, i, 32'h100 + i);
      end
      if (i == 1) begin
        n_checks++; if (occupancy !== 3'd3 || in_ready !== 1'b1) begin n_errors++; $display("FAIL full_pop_only: got occ=%0d ready=%0b expected 3/1", occupancy, in_ready); end
      end
    end
    sa_grant = 1'b0;
    n_checks++; if (occupancy !== 3'd0 || sa_request !== 1'b0) begin n_errors++; $display("FAIL fill_empty: got occ=%0d req=%0b expected 0/0", occupancy, sa_request); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_info = INFO_BROADCAST; in_addr = 8'h11 + 8'(i); in_data = 32'hB0 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (occupancy !== 3'd3) begin n_errors++; $display("FAIL wrap_occupancy: got %0d expected 3", occupancy); end
    sa_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (st_addr !== 8'h11 + 8'(i) || st_data !== 32'hB0 + 32'(i)) begin
        n_errors++; $display("FAIL wrap_order_%0d: got addr=%0h data=%0h expected %0h/%0h", i, st_addr, st_data, 8'h11 + i, 32'hB0 + i);
      end
    end
    sa_grant = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_info = INFO_BROADCAST; in_addr = 8'h20 + 8'(i); in_data = 32'hC0 + 32'(i);
      tick();
    end
    sa_grant = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_addr = 8'h22 + 8'(i); in_data = 32'hC2 + 32'(i);
      tick();
      n_checks++; if (occupancy !== 3'd2) begin n_errors++; $display("FAIL b2b_occupancy_%0d: got %0d expected 2", i, occupancy); end
      n_checks++; if (st_valid !== 1'b1 || st_addr !== 8'h20 + 8'(i)) begin
        n_errors++; $display("FAIL b2b_order_%0d: got valid=%0b addr=%0h expected 1/%0h", i, st_valid, st_addr, 8'h20 + i);
      end
    end
    in_valid = 1'b0;
    for (int i = 6; i < 8; i++) begin
      tick();
      n_checks++; if (st_addr !== 8'h20 + 8'(i) || st_data !== 32'hC0 + 32'(i)) begin
        n_errors++; $display("FAIL b2b_tail_%0d: got addr=%0h data=%0h expected %0h/%0h", i, st_addr, st_data, 8'h20 + i, 32'hC0 + i);
      end
    end
    sa_grant = 1'b0;
    n_checks++; if (occupancy !== 3'd0) begin n_errors++; $display("FAIL b2b_empty: got %0d expected 0", occupancy); end
    tick();
  endtask

  task automatic test_starvation();
    for (int round = 0; round < 2; round++) begin
      in_valid = 1'b1; in_info = INFO_BROADCAST; in_addr = 8'h30 + 8'(round); in_data = 32'hD0;
      tick();
      in_valid = 1'b0;
      // now in the cycle where sa_request first reads 1
      for (int k = 0; k <= STARVE_LIMIT + 1; k++) begin
        n_checks++; if (sa_starve !== (k == STARVE_LIMIT + 1)) begin
          n_errors++; $display("FAIL starve_r%0d_k%0d: got %0b expected %0b", round, k, sa_starve, (k == STARVE_LIMIT + 1));
        end
        if (k <= STARVE_LIMIT) tick();
      end
      sa_grant = 1'b1;
      tick();
      sa_grant = 1'b0;
      n_checks++; if (sa_starve !== 1'b0) begin n_errors++; $display("FAIL starve_clear_r%0d: got %0b expected 0", round, sa_starve); end
      n_checks++; if (st_valid !== 1'b1 || st_addr !== 8'h30 + 8'(round)) begin
        n_errors++; $display("FAIL starve_pop_r%0d: got valid=%0b addr=%0h expected 1/%0h", round, st_valid, st_addr, 8'h30 + round);
      end
      tick();
    end
  endtask

  task automatic test_spurious_grant();
    sa_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (st_valid !== 1'b0 || occupancy !== 3'd0 || in_ready !== 1'b1) begin
        n_errors++; $display("FAIL spurious_%0d: got valid=%0b occ=%0d ready=%0b expected 0/0/1", i, st_valid, occupancy, in_ready);
      end
    end
    sa_grant = 1'b0;
    n_checks++; if (sa_info !== 2'd0 || sa_addr !== 8'd0) begin n_errors++; $display("FAIL spurious_sa_fields: got info=%0d addr=%0d expected 0/0", sa_info, sa_addr); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_info = INFO_FIN_BROADCAST; in_addr = 8'h40 + 8'(i); in_data = 32'hDEAD0000 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    sa_grant = 1'b1;
    tick();
    sa_grant = 1'b0;
    n_checks++; if (occupancy !== 3'd3 || st_valid !== 1'b1 || st_data !== 32'hDEAD0000) begin
      n_errors++; $display("FAIL midrst_pre: got occ=%0d valid=%0b data=%0h expected 3/1/dead0000", occupancy, st_valid, st_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (occupancy !== 3'd0) begin n_errors++; $display("FAIL midrst_occupancy: got %0d expected 0", occupancy); end
    n_checks++; if (st_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_st_valid: got %0b expected 0", st_valid); end
    n_checks++; if (st_data !== 32'd0 || st_addr !== 8'd0 || st_info !== 2'd0) begin
      n_errors++; $display("FAIL midrst_st_fields: got info=%0d addr=%0h data=%0h expected 0/0/0", st_info, st_addr, st_data);
    end
    n_checks++; if (sa_request !== 1'b0) begin n_errors++; $display("FAIL midrst_request: got %0b expected 0", sa_request); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL midrst_in_ready: got %0b expected 1", in_ready); end
    n_checks++; if (sa_starve !== 1'b0) begin n_errors++; $display("FAIL midrst_starve: got %0b expected 0", sa_starve); end
  endtask

  initial begin
    tick();
    test_reset();
    test_single_flit();
    test_fill_wrap();
    test_back_to_back();
    test_starvation();
    test_spurious_grant();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
